// File: rtl/stock_keeper.sv
// Per-item stock register file with deal commit, operator restock and sales ledger.
// Define STOCK_SALES_LOG_EN to build the sold1..4 / revenue accumulators.
module stock_keeper #(
    parameter logic [7:0] INIT_STOCK = 8'd10,
    parameter logic [7:0] MAX_STOCK  = 8'd99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        deal_flag,
    input  logic [7:0]  require_money,
    input  logic [7:0]  newnum1,
    input  logic [7:0]  newnum2,
    input  logic [7:0]  newnum3,
    input  logic [7:0]  newnum4,
    input  logic [7:0]  sellnum1,
    input  logic [7:0]  sellnum2,
    input  logic [7:0]  sellnum3,
    input  logic [7:0]  sellnum4,
    input  logic        restock_mode,
    input  logic        add1,
    input  logic        add2,
    input  logic        add3,
    input  logic        add4,
    output logic [7:0]  nownum1,
    output logic [7:0]  nownum2,
    output logic [7:0]  nownum3,
    output logic [7:0]  nownum4,
    output logic [3:0]  soldout,
    output logic        busy,
    output logic        deal_dropped,
    output logic [7:0]  sold1,
    output logic [7:0]  sold2,
    output logic [7:0]  sold3,
    output logic [7:0]  sold4,
    output logic [15:0] revenue
);

    typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_RESTOCK} state_t;

    state_t          state_q, state_d;
    logic            flag_q, flag_d;
    logic            armed_q, armed_d;
    logic            drop_q, drop_d;
    logic [3:0][7:0] now_q, now_d;
    logic [3:0][7:0] newnum, sellnum;
    logic [3:0]      add;
    logic            deal_edge, deal_ok, commit;

    assign newnum  = {newnum4, newnum3, newnum2, newnum1};
    assign sellnum = {sellnum4, sellnum3, sellnum2, sellnum1};
    assign add     = {add4, add3, add2, add1};

    // armed_q masks the first cycle after reset so a flag already high at release is not an edge
    assign deal_edge = deal_flag & ~flag_q & armed_q;

    always_comb begin
        deal_ok = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (newnum[i] > now_q[i] || sellnum[i] != (now_q[i] - newnum[i]))
                deal_ok = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        now_d   = now_q;
        drop_d  = drop_q;
        flag_d  = deal_flag;
        armed_d = 1'b1;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (deal_edge)
                    state_d = S_COMMIT;
                else if (restock_mode)
                    state_d = S_RESTOCK;
            end
            S_COMMIT: begin
                if (deal_ok) begin
                    now_d  = newnum;
                    commit = 1'b1;
                end else begin
                    drop_d = 1'b1;
                end
                state_d = restock_mode ? S_RESTOCK : S_IDLE;
            end
            S_RESTOCK: begin
                // stock at or above the ceiling is left untouched
                for (int unsigned i = 0; i < 4; i++) begin
                    if (add[i] && now_q[i] < MAX_STOCK)
                        now_d[i] = now_q[i] + 8'd1;
                end
                if (deal_edge)
                    drop_d = 1'b1;
                if (!restock_mode)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            flag_q  <= 1'b0;
            armed_q <= 1'b0;
            drop_q  <= 1'b0;
            now_q   <= {4{INIT_STOCK}};
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            armed_q <= armed_d;
            drop_q  <= drop_d;
            now_q   <= now_d;
        end
    end

    assign nownum1      = now_q[0];
    assign nownum2      = now_q[1];
    assign nownum3      = now_q[2];
    assign nownum4      = now_q[3];
    assign busy         = (state_q == S_COMMIT);
    assign deal_dropped = drop_q;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++)
            soldout[i] = (now_q[i] == 8'd0);
    end

`ifdef STOCK_SALES_LOG_EN
    logic [3:0][7:0] sold_q, sold_d;
    logic [15:0]     rev_q, rev_d;
    logic [3:0][8:0] sold_sum;
    logic [16:0]     rev_sum;

    always_comb begin
        sold_d  = sold_q;
        rev_d   = rev_q;
        rev_sum = {1'b0, rev_q} + {9'd0, require_money};
        for (int unsigned i = 0; i < 4; i++)
            sold_sum[i] = {1'b0, sold_q[i]} + {1'b0, sellnum[i]};
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++)
                sold_d[i] = sold_sum[i][8] ? 8'hFF : sold_sum[i][7:0];
            rev_d = rev_sum[16] ? 16'hFFFF : rev_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sold_q <= '0;
            rev_q  <= '0;
        end else begin
            sold_q <= sold_d;
            rev_q  <= rev_d;
        end
    end

    assign sold1   = sold_q[0];
    assign sold2   = sold_q[1];
    assign sold3   = sold_q[2];
    assign sold4   = sold_q[3];
    assign revenue = rev_q;
`else
    logic unused_stats;
    assign unused_stats = ^{require_money, commit};

    assign sold1   = '0;
    assign sold2   = '0;
    assign sold3   = '0;
    assign sold4   = '0;
    assign revenue = '0;
`endif

endmodule

// File: tb/tb_stock_keeper.sv
// Scoreboard bench for stock_keeper: expected output snapshots are queued at stimulus time.
module tb_stock_keeper;

    localparam logic [7:0] INIT = 8'd10;
    localparam logic [7:0] MAXS = 8'd99;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        deal_flag = 1'b0;
    logic [7:0]  require_money = '0;
    logic [7:0]  newnum1 = '0, newnum2 = '0, newnum3 = '0, newnum4 = '0;
    logic [7:0]  sellnum1 = '0, sellnum2 = '0, sellnum3 = '0, sellnum4 = '0;
    logic        restock_mode = 1'b0;
    logic        add1 = 1'b0, add2 = 1'b0, add3 = 1'b0, add4 = 1'b0;
    logic [7:0]  nownum1, nownum2, nownum3, nownum4;
    logic [3:0]  soldout;
    logic        busy, deal_dropped;
    logic [7:0]  sold1, sold2, sold3, sold4;
    logic [15:0] revenue;

    always #5 clk = ~clk;

    stock_keeper #(.INIT_STOCK(INIT), .MAX_STOCK(MAXS)) dut (
        .clk(clk), .rst(rst), .deal_flag(deal_flag), .require_money(require_money),
        .newnum1(newnum1), .newnum2(newnum2), .newnum3(newnum3), .newnum4(newnum4),
        .sellnum1(sellnum1), .sellnum2(sellnum2), .sellnum3(sellnum3), .sellnum4(sellnum4),
        .restock_mode(restock_mode),
        .add1(add1), .add2(add2), .add3(add3), .add4(add4),
        .nownum1(nownum1), .nownum2(nownum2), .nownum3(nownum3), .nownum4(nownum4),
        .soldout(soldout), .busy(busy), .deal_dropped(deal_dropped),
        .sold1(sold1), .sold2(sold2), .sold3(sold3), .sold4(sold4),
        .revenue(revenue)
    );

    typedef struct packed {
        logic            busy;
        logic            drop;
        logic [3:0]      so;
        logic [15:0]     rev;
        logic [3:0][7:0] sold;
        logic [3:0][7:0] now;
    } snap_t;

    int checks = 0;
    int errors = 0;
    snap_t q[$];

    logic [3:0][7:0] m_now, m_sold;
    logic [15:0]     m_rev;
    logic            m_drop;

    function automatic snap_t model_snap();
        snap_t s;
        s.busy = 1'b0;
        s.drop = m_drop;
        for (int i = 0; i < 4; i++) s.so[i] = (m_now[i] == 8'd0);
        s.rev  = m_rev;
        s.sold = m_sold;
        s.now  = m_now;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.busy = busy;
        s.drop = deal_dropped;
        s.so   = soldout;
        s.rev  = revenue;
        s.sold = {sold4, sold3, sold2, sold1};
        s.now  = {nownum4, nownum3, nownum2, nownum1};
        return s;
    endfunction

    function automatic void model_reset();
        m_now  = {4{INIT}};
        m_sold = '0;
        m_rev  = '0;
        m_drop = 1'b0;
    endfunction

    function automatic void model_commit(input logic [3:0][7:0] nn, input logic [3:0][7:0] sn,
                                         input logic [7:0] money);
        logic ok;
        int   s;
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (nn[i] > m_now[i] || sn[i] != 8'(m_now[i] - nn[i])) ok = 1'b0;
        if (ok) begin
            m_now = nn;
`ifdef STOCK_SALES_LOG_EN
            for (int i = 0; i < 4; i++) begin
                s = int'(m_sold[i]) + int'(sn[i]);
                m_sold[i] = (s > 255) ? 8'hFF : 8'(s);
            end
            s = int'(m_rev) + int'(money);
            m_rev = (s > 65535) ? 16'hFFFF : 16'(s);
`else
            s = int'(money);
`endif
        end else begin
            m_drop = 1'b1;
        end
    endfunction

    function automatic void model_add(input logic [3:0] mask);
        for (int i = 0; i < 4; i++)
            if (mask[i] && m_now[i] < MAXS) m_now[i] = m_now[i] + 8'd1;
    endfunction

    task automatic drive_deal(input logic [3:0][7:0] nn, input logic [3:0][7:0] sn,
                              input logic [7:0] money);
        {newnum4, newnum3, newnum2, newnum1}     = nn;
        {sellnum4, sellnum3, sellnum2, sellnum1} = sn;
        require_money = money;
        deal_flag     = 1'b1;
    endtask

    task automatic pulse_add(input logic [3:0] mask);
        @(posedge clk); #1;
        {add4, add3, add2, add1} = mask;
        @(posedge clk); #1;
        {add4, add3, add2, add1} = 4'b0000;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        model_reset();
    endtask

    // Full deal: edge at N (busy checked), commit at N+1 (snapshot checked), flag then drops.
    task automatic do_deal(input string name, input logic [3:0][7:0] nn,
                           input logic [3:0][7:0] sn, input logic [7:0] money);
        snap_t exp, got;
        model_commit(nn, sn, money);
        q.push_back(model_snap());
        @(posedge clk); #1;
        drive_deal(nn, sn, money);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: got %b expected 1", name, busy);
        end
        @(posedge clk);
        @(negedge clk);
        exp = q.pop_front();
        got = dut_snap();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
        deal_flag = 1'b0;
    endtask

    task automatic test_reset();
        snap_t exp, got;
        do_reset();
        q.push_back(model_snap());
        @(negedge clk);
        exp = q.pop_front();
        got = dut_snap();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, exp);
        end
        checks++;
        if (nownum1 !== 8'd10 || soldout !== 4'h0 || revenue !== 16'h0) begin
            errors++;
            $display("FAIL reset_const: got now1=%0d so=%h rev=%h expected 10 0 0", nownum1, soldout, revenue);
        end
    endtask

    task automatic test_deal();
        do_deal("first_deal", {8'd10, 8'd9, 8'd10, 8'd8}, {8'd0, 8'd1, 8'd0, 8'd2}, 8'd21);
        checks++;
        if (nownum1 !== 8'd8 || nownum3 !== 8'd9) begin
            errors++;
            $display("FAIL first_deal_stock: got %0d %0d expected 8 9", nownum1, nownum3);
        end
    endtask

    task automatic test_restock();
        snap_t exp, got;
        // add2 sampled on the entry edge must not count
        @(posedge clk); #1;
        restock_mode = 1'b1;
        add2 = 1'b1;
        @(posedge clk); #1;
        add2 = 1'b0;
        q.push_back(model_snap());
        @(negedge clk);
        exp = q.pop_front(); got = dut_snap(); checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL restock_entry: got %h expected %h", got, exp);
        end
        for (int k = 0; k < 95; k++) begin
            pulse_add(4'b0001);
            model_add(4'b0001);
        end
        q.push_back(model_snap());
        @(negedge clk);
        exp = q.pop_front(); got = dut_snap(); checks++;
        if (got !== exp || nownum1 !== 8'd99) begin
            errors++;
            $display("FAIL restock_sat: got %h expected %h", got, exp);
        end
        pulse_add(4'b1111);
        model_add(4'b1111);
        q.push_back(model_snap());
        @(negedge clk);
        exp = q.pop_front(); got = dut_snap(); checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL restock_multi: got %h expected %h", got, exp);
        end
        @(posedge clk); #1;
        restock_mode = 1'b0;
        pulse_add(4'b0100);
        q.push_back(model_snap());
        @(negedge clk);
        exp = q.pop_front(); got = dut_snap(); checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL idle_add_ignored: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_restock_drop();
        snap_t exp, got;
        logic [3:0][7:0] nn, sn;
        nn = m_now; nn[1] = m_now[1] - 8'd1;
        sn = '0;    sn[1] = 8'd1;
        @(posedge clk); #1;
        restock_mode = 1'b1;
        @(posedge clk); #1;
        drive_deal(nn, sn, 8'd7);
        m_drop = 1'b1;
        q.push_back(model_snap());
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp = q.pop_front(); got = dut_snap(); checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL restock_deal_drop: got %h expected %h", got, exp);
        end
        deal_flag = 1'b0;
        restock_mode = 1'b0;
        repeat (2) @(posedge clk);
        nn = m_now; nn[0] = m_now[0] - 8'd3;
        sn = '0;    sn[0] = 8'd3;
        do_deal("drop_sticky", nn, sn, 8'd12);
    endtask

    task automatic test_reject();
        do_reset();
        do_deal("reject_over", {8'd10, 8'd10, 8'd10, 8'd12}, {8'd0, 8'd0, 8'd0, 8'd0}, 8'd5);
        do_deal("reject_sellnum", {8'd10, 8'd10, 8'd10, 8'd9}, {8'd0, 8'd0, 8'd0, 8'd2}, 8'd5);
        checks++;
        if (nownum1 !== 8'd10 || deal_dropped !== 1'b1) begin
            errors++;
            $display("FAIL reject_const: got now1=%0d drop=%b expected 10 1", nownum1, deal_dropped);
        end
    endtask

    task automatic test_soldout_and_async_reset();
        snap_t exp, got;
        logic [3:0][7:0] nn, sn;
        nn = m_now; nn[3] = 8'd0;
        sn = '0;    sn[3] = m_now[3];
        do_deal("sell_item4", nn, sn, 8'd40);
        checks++;
        if (soldout !== 4'b1000) begin
            errors++;
            $display("FAIL soldout: got %b expected 1000", soldout);
        end
        nn = m_now; nn[0] = m_now[0] - 8'd1;
        sn = '0;    sn[0] = 8'd1;
        @(posedge clk); #1;
        drive_deal(nn, sn, 8'd9);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        model_reset();
        q.push_back(model_snap());
        exp = q.pop_front(); got = dut_snap(); checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", got, exp);
        end
        // flag stays high across release: must not commit
        @(posedge clk); #1;
        rst = 1'b1;
        q.push_back(model_snap());
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp = q.pop_front(); got = dut_snap(); checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL flag_high_release: got %h expected %h", got, exp);
        end
        deal_flag = 1'b0;
    endtask

    task automatic test_revenue_sat();
        for (int k = 0; k < 256; k++) do_deal("rev_fill", m_now, '0, 8'd255);
        do_deal("rev_fff0", m_now, '0, 8'd240);
        do_deal("rev_sat", m_now, '0, 8'd30);
        checks++;
`ifdef STOCK_SALES_LOG_EN
        if (revenue !== 16'hFFFF) begin
            errors++;
            $display("FAIL rev_sat_const: got %h expected ffff", revenue);
        end
`else
        if (revenue !== 16'h0000) begin
            errors++;
            $display("FAIL rev_disabled: got %h expected 0000", revenue);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_deal();
        test_restock();
        test_restock_drop();
        test_reject();
        test_soldout_and_async_reset();
        test_revenue_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stock_keeper.md
# stock_keeper

Inventory register file and sales ledger that sits directly downstream of the payment FSM. It holds the live per-item stock counts that feed the payment stage's `nownum1..4` inputs. On each successful deal (rising edge of the payment `flag`), it commits the post-deal counts and accumulates sales statistics. In operator restock mode it increments stock from per-item button pulses.

## Interface
Parameters:
- `INIT_STOCK`, 8'd10, stock of every item after reset
- `MAX_STOCK`, 8'd99, restock saturation ceiling (must be ≤ 8'd255)

Ports:
- `clk`  in  1  system clock; every register is on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `deal_flag`  in  1  payment success level from the payment stage; high ≥ 1 `clk`
- `require_money`  in  8  amount charged for the deal, sampled at commit
- `newnum1..4`  in  8 each  post-deal stock per item, sampled at commit
- `sellnum1..4`  in  8 each  units sold per item in this deal
- `restock_mode`  in  1  operator restock switch (already debounced)
- `add1..4`  in  1 each  single-`clk` pulse: add one unit of item i
- `nownum1..4`  out  8 each  current stock; wired to the payment stage
- `soldout`  out  4  bit i-1 = (`nownum`i == 0), combinational from the registers
- `busy`  out  1  high in S_COMMIT
- `deal_dropped`  out  1  sticky error flag; cleared only by reset
- `sold1..4`  out  8 each  cumulative units sold (SALES_LOG_EN only)
- `revenue`  out  16  cumulative money taken (SALES_LOG_EN only)

## Operation
- Reset values:
  - `nownum`i = INIT_STOCK
  - `sold`i = 0, `revenue` = 0
  - `busy` = 0, `deal_dropped` = 0
  - FSM = S_IDLE
  - edge register `flag_q` = 0
  - `soldout` = 4'hF if INIT_STOCK == 0, otherwise 4'h0
- Edge detect: `deal_edge = deal_flag & ~flag_q`; `flag_q <= deal_flag` every cycle.
- FSM states:
  - S_IDLE
    - `deal_edge` → S_COMMIT. This has priority over a simultaneous `restock_mode`.
    - Else `restock_mode` == 1 → S_RESTOCK.
    - Else stay.
  - S_COMMIT (exactly one cycle, `busy` = 1)
    - Consistency check: `newnum`i ≤ `nownum`i for all i, and `sellnum`i == `nownum`i − `newnum`i.
    - If it passes: `nownum`i <= `newnum`i, and statistics update.
    - If it fails: no register changes and `deal_dropped` <= 1.
    - Next state is S_RESTOCK if `restock_mode`, else S_IDLE.
  - S_RESTOCK
    - Each `add`i pulse: `nownum`i <= min(`nownum`i + 1, MAX_STOCK).
    - Stock already above MAX_STOCK is left unchanged.
    - Multiple simultaneous `add` pulses all apply in the same cycle.
    - `deal_edge` here is not committed; `deal_dropped` <= 1.
    - `restock_mode` == 0 → S_IDLE.
- `add` pulses are ignored outside S_RESTOCK.
- Arithmetic:
  - `sold`i += `sellnum`i, saturating at 8'hFF.
  - `revenue` += zero-extended `require_money`, saturating at 16'hFFFF.
  - Compare and add in 9/17 bits; clamp on carry.
- Reset asserted mid-commit: all registers return to reset values immediately (asynchronous); nothing from the partial deal is kept.
- `deal_flag` already high when reset releases: no edge, and no commit until it falls and rises again.

## Timing
- Deal latency:
  - `deal_flag` rises before clock edge N → `flag_q` high and FSM in S_COMMIT after edge N.
  - `nownum`, `sold`, `revenue` update at edge N+1.
  - The payment stage sees the new stock from cycle N+1.
- `newnum`, `sellnum` and `require_money` must be stable from edge N through edge N+1. The payment stage holds them static while `flag` is high.
- Restock:
  - `add` pulse sampled at edge N → `nownum` updated after edge N.
  - Entering restock costs one cycle: `restock_mode` sampled at edge N means S_RESTOCK from N, so the first usable `add` is at edge N+1.
- Back-to-back deals are impossible: `flag` must fall between deals. A second edge while in S_COMMIT cannot occur, because `flag_q` is already high.

## Configuration
- `STOCK_SALES_LOG_EN`:
  - Defined: `sold1..4` and `revenue` accumulators are instantiated and behave as specified.
  - Undefined: the accumulators are not built; `sold1..4` and `revenue` are driven constant 0.
- Stock tracking, FSM, `soldout` and `deal_dropped` are identical either way.

## Test plan
- Reset release → `nownum1..4` = 10, `soldout` = 0, `revenue` = 0. Then `deal_flag` rises with `newnum` = {8,10,9,10}, `sellnum` = {2,0,1,0}, `require_money` = 21 → two cycles later `nownum` = {8,10,9,10}, `sold1` = 2, `sold3` = 1, `revenue` = 21, `busy` high for exactly one cycle.
- Enter restock, 95 `add1` pulses from `nownum1` = 8 → `nownum1` saturates at 99. Leave restock → S_IDLE.
- Deal edge while `restock_mode` = 1 → stock unchanged, `deal_dropped` = 1 and stays 1 until `rst` = 0.
- Deal with `newnum1` = 12 > `nownum1` = 10 → commit rejected, `nownum1` stays 10, `deal_dropped` = 1.
- Sell all 10 units of item 4 → `soldout` = 4'b1000. Then `rst` pulses low mid-S_COMMIT of another deal → all outputs return to reset values asynchronously.
- With `STOCK_SALES_LOG_EN` defined, `revenue` preloaded near 16'hFFF0 plus a deal of 30 → `revenue` = 16'hFFFF. With the macro undefined, `revenue` = 0 after the deal.
